// File: rtl/wave_pwm_out.sv
// wave_pwm_out: PWM output stage with a one-entry sample holding register and duty reload
// at period boundaries. Define WAVE_PWM_CENTER_EN for a center-aligned (up/down) counter.
module wave_pwm_out #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

`ifdef WAVE_PWM_CENTER_EN
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] CNT_RST = '0;

    dir_e dir_q, dir_d;
`else
    localparam logic [WIDTH-1:0] CNT_RST = CNT_LAST;
`endif

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             pwm_q, pwm_d;
    logic             ps_q, ps_d;
    logic             ur_q, ur_d;

    logic tick;
    logic boundary;
    logic accept;
    logic load;

    // Prescaler and period counter; disabling parks the counter so the
    // first tick after re-enabling is a period boundary.
    always_comb begin
        tick     = enable && (pre_q == PRE_LAST);
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
`ifdef WAVE_PWM_CENTER_EN
        dir_d    = dir_q;
`endif
        if (!enable) begin
            pre_d = '0;
            cnt_d = CNT_RST;
`ifdef WAVE_PWM_CENTER_EN
            dir_d = DIR_DOWN;
`endif
        end else begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
`ifdef WAVE_PWM_CENTER_EN
                // Endpoint values repeat: the turn-around tick flips direction only.
                if (dir_q == DIR_DOWN) begin
                    if (cnt_q == '0) begin
                        boundary = 1'b1;
                        dir_d    = DIR_UP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    if (cnt_q == CNT_LAST) begin
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`else
                if (cnt_q == CNT_LAST) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
        end
    end

    // Holding register: accept and boundary-load are exclusive because they
    // need opposite fill states, so no sample ever bypasses hold into duty.
    always_comb begin
        accept = sample_valid && !full_q;
        load   = boundary && full_q;
        hold_d = accept ? sample_in : hold_q;
        duty_d = load ? hold_q : duty_q;
        full_d = full_q;
        if (accept) begin
            full_d = 1'b1;
        end else if (load) begin
            full_d = 1'b0;
        end
        pwm_d = enable && (cnt_q < duty_q);
        ps_d  = boundary;
        ur_d  = boundary && !full_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q  <= '0;
            cnt_q  <= CNT_RST;
            duty_q <= '0;
            hold_q <= '0;
            full_q <= 1'b0;
            pwm_q  <= 1'b0;
            ps_q   <= 1'b0;
            ur_q   <= 1'b0;
`ifdef WAVE_PWM_CENTER_EN
            dir_q  <= DIR_DOWN;
`endif
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            hold_q <= hold_d;
            full_q <= full_d;
            pwm_q  <= pwm_d;
            ps_q   <= ps_d;
            ur_q   <= ur_d;
`ifdef WAVE_PWM_CENTER_EN
            dir_q  <= dir_d;
`endif
        end
    end

    assign sample_ready = !full_q;
    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_wave_pwm_out.sv
// Bench for wave_pwm_out: two instances (PRESCALE 1 and 4) checked every clock against a
// phase-position reference model, plus directed period-length and high-time checks.
module tb_wave_pwm_out;

    localparam int MAXV       = 255;
    localparam int PRESCALE_B = 4;
`ifdef WAVE_PWM_CENTER_EN
    localparam int PERIOD = 2 * MAXV;
    localparam int HSCALE = 2;
`else
    localparam int PERIOD = MAXV;
    localparam int HSCALE = 1;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b0;
    logic [7:0] sampleIn = '0;
    logic       validA   = 1'b0;
    logic       validB   = 1'b0;
    logic       readyA, pwmA, psA, urA;
    logic       readyB, pwmB, psB, urB;

    int compareCount = 0;
    int failCount    = 0;
    int cycleNo      = 0;

    typedef struct {
        int pre;
        int ph;
        int duty;
        int hold;
        bit full;
        bit pwm;
        bit ps;
        bit ur;
    } model_t;

    model_t mA, mB;
    bit     accA, accB;
    logic   psAtAccA;
    int     lenA = 0, hiA = 0, urCntA = 0, lenB = 0, hiB = 0;
    int     lenQA[$], highQA[$], urQA[$], lenQB[$], highQB[$];

    always #5 clk = ~clk;

    wave_pwm_out #(.WIDTH(8), .PRESCALE(1)) dutA (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sampleIn), .sample_valid(validA),
        .sample_ready(readyA), .pwm_out(pwmA), .period_start(psA), .underrun(urA)
    );

    wave_pwm_out #(.WIDTH(8), .PRESCALE(PRESCALE_B)) dutB (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sampleIn), .sample_valid(validB),
        .sample_ready(readyB), .pwm_out(pwmB), .period_start(psB), .underrun(urB)
    );

    // Counter value seen at a given position within the period.
    function automatic int levelAt(input int ph);
        if (HSCALE == 1) return ph;
        return (ph < MAXV) ? ph : (2 * MAXV - 1 - ph);
    endfunction

    function automatic model_t resetModel();
        model_t m;
        m    = '{default: 0};
        m.ph = PERIOD - 1;
        return m;
    endfunction

    function automatic model_t modelStep(input model_t s, input bit rstn, input bit en,
                                         input bit valid, input int din, input int presc);
        model_t n;
        bit     tick, bnd;
        if (!rstn) return resetModel();
        n     = s;
        tick  = en && (s.pre == presc - 1);
        bnd   = tick && (s.ph == PERIOD - 1);
        n.pwm = en && (levelAt(s.ph) < s.duty);
        n.ps  = bnd;
        n.ur  = bnd && !s.full;
        if (!en) begin
            n.pre = 0;
            n.ph  = PERIOD - 1;
        end else begin
            n.pre = tick ? 0 : s.pre + 1;
            if (tick) n.ph = (s.ph + 1) % PERIOD;
        end
        if (bnd && s.full) begin
            n.duty = s.hold;
            n.full = 1'b0;
        end
        if (valid && !s.full) begin
            n.hold = din;
            n.full = 1'b1;
        end
        return n;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0b expected=%0b cycle=%0d", tag, obs, exp, cycleNo);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cycleNo);
        end
    endtask

    task automatic checkAtLeast(input string tag, input int obs, input int lim);
        compareCount++;
        assert ((obs >= lim) === 1'b1) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected>=%0d cycle=%0d", tag, obs, lim, cycleNo);
        end
    endtask

    task automatic checkOutput();
        checkBit("readyA", readyA, !mA.full);
        checkBit("pwmA",   pwmA,   mA.pwm);
        checkBit("psA",    psA,    mA.ps);
        checkBit("urA",    urA,    mA.ur);
        checkBit("readyB", readyB, !mB.full);
        checkBit("pwmB",   pwmB,   mB.pwm);
        checkBit("psB",    psB,    mB.ps);
        checkBit("urB",    urB,    mB.ur);
    endtask

    // Per-period statistics: an interval runs from just after one period_start
    // sample up to and including the next one.
    task automatic monitor();
        lenA++; lenB++;
        if (pwmA === 1'b1) hiA++;
        if (urA === 1'b1) urCntA++;
        if (pwmB === 1'b1) hiB++;
        if (psA === 1'b1) begin
            lenQA.push_back(lenA); highQA.push_back(hiA); urQA.push_back(urCntA);
            lenA = 0; hiA = 0; urCntA = 0;
        end
        if (psB === 1'b1) begin
            lenQB.push_back(lenB); highQB.push_back(hiB);
            lenB = 0; hiB = 0;
        end
    endtask

    task automatic cycle();
        logic prevPs;
        prevPs = psA;
        @(posedge clk);
        accA = rst && validA && !mA.full;
        accB = rst && validB && !mB.full;
        if (accA) psAtAccA = prevPs;
        mA = modelStep(mA, rst, enable, validA, int'(sampleIn), 1);
        mB = modelStep(mB, rst, enable, validB, int'(sampleIn), PRESCALE_B);
        cycleNo++;
        #1;
        checkOutput();
        monitor();
    endtask

    task automatic applyStimulus(input int v, input bit useA, input bit useB);
        int budget;
        bit doneA, doneB;
        budget   = 2 * PERIOD * PRESCALE_B + 20;
        doneA    = !useA;
        doneB    = !useB;
        sampleIn = 8'(v);
        validA   = useA;
        validB   = useB;
        while (!(doneA && doneB) && budget > 0) begin
            cycle();
            if (accA) begin doneA = 1'b1; validA = 1'b0; end
            if (accB) begin doneB = 1'b1; validB = 1'b0; end
            budget--;
        end
        validA = 1'b0;
        validB = 1'b0;
        checkBit("accept", doneA && doneB, 1'b1);
    endtask

    task automatic waitPeriods(input int which, input int n);
        int target, budget;
        target = ((which == 0) ? lenQA.size() : lenQB.size()) + n;
        budget = (n + 1) * PERIOD * ((which == 0) ? 1 : PRESCALE_B) + 20;
        while (((which == 0) ? lenQA.size() : lenQB.size()) < target && budget > 0) begin
            cycle();
            budget--;
        end
        checkAtLeast("periodCount", (which == 0) ? lenQA.size() : lenQB.size(), target);
    endtask

    task automatic checkLastPeriodsA(input string tag, input int nLast, input int expHigh,
                                     input int expUr);
        int first;
        checkAtLeast({tag, "_count"}, lenQA.size(), nLast);
        first = (lenQA.size() > nLast) ? lenQA.size() - nLast : 0;
        for (int i = first; i < lenQA.size(); i++) begin
            checkInt({tag, "_len"}, lenQA[i], PERIOD);
            checkInt({tag, "_high"}, highQA[i], expHigh);
            if (expUr >= 0) checkInt({tag, "_underrun"}, urQA[i], expUr);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startIdx;
        mA = resetModel();
        mB = resetModel();

        // Reset held with a valid sample offered: nothing may be accepted.
        rst = 1'b0; enable = 1'b0; validA = 1'b1; validB = 1'b1; sampleIn = 8'd77;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checkBit("rst_ready", readyA, 1'b1);
            checkBit("rst_pwm", pwmA, 1'b0);
            checkBit("rst_ps", psA, 1'b0);
            checkBit("rst_ur", urA, 1'b0);
        end
        validA = 1'b0; validB = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        checkBit("noAcceptInReset", readyA, 1'b1);

        $display("[TB] duty 64");
        enable = 1'b1;
        applyStimulus(64, 1'b1, 1'b1);
        waitPeriods(0, 3);
        checkLastPeriodsA("duty64", 2, 64 * HSCALE, -1);

        $display("[TB] duty 0 then 255");
        applyStimulus(0, 1'b1, 1'b1);
        waitPeriods(0, 4);
        checkLastPeriodsA("duty0", 3, 0, -1);
        applyStimulus(255, 1'b1, 1'b1);
        waitPeriods(0, 4);
        checkLastPeriodsA("duty255", 3, PERIOD, -1);

        $display("[TB] single sample then underruns");
        applyStimulus(100, 1'b1, 1'b1);
        waitPeriods(0, 4);
        checkLastPeriodsA("duty100", 3, 100 * HSCALE, 1);
        waitPeriods(1, 2);
        checkInt("prescaleLen", lenQB[lenQB.size() - 1], PERIOD * PRESCALE_B);
        checkInt("prescaleHigh", highQB[highQB.size() - 1], 100 * HSCALE * PRESCALE_B);

        $display("[TB] back-to-back 10 then 20");
        startIdx = lenQA.size();
        applyStimulus(10, 1'b1, 1'b0);
        applyStimulus(20, 1'b1, 1'b0);
        checkBit("stallEndsAfterBoundary", psAtAccA, 1'b1);
        waitPeriods(0, 2);
        checkAtLeast("b2bCount", highQA.size(), startIdx + 3);
        if (highQA.size() >= startIdx + 3) begin
            checkInt("b2bDuty10", highQA[startIdx + 1], 10 * HSCALE);
            checkInt("b2bDuty20", highQA[startIdx + 2], 20 * HSCALE);
        end

        $display("[TB] reset mid-period with hold full");
        applyStimulus(50, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cycle();
        rst = 1'b0;
        cycle();
        checkBit("midRst_pwmB", pwmB, 1'b0);
        checkBit("midRst_readyB", readyB, 1'b1);
        checkBit("midRst_psB", psB, 1'b0);
        checkBit("midRst_urB", urB, 1'b0);
        checkBit("midRst_readyA", readyA, 1'b1);
        checkBit("midRst_pwmA", pwmA, 1'b0);
        rst = 1'b1;
        waitPeriods(1, 2);
        checkInt("postRstHighB", highQB[highQB.size() - 1], 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) enable = !enable;
            rst      = ($urandom_range(0, 999) != 0);
            validA   = ($urandom_range(0, 2) == 0);
            validB   = validA ^ ($urandom_range(0, 3) == 0);
            sampleIn = 8'($urandom_range(0, 255));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
